// File: rtl/data_mem_sync.sv
// Single-port word-addressed data memory with byte-enable writes and a
// registered read path behind a valid/ready request interface. After every
// reset an init sequencer clears all words before requests are accepted.
//
// Ports:
//   clk        - clock, all state on rising edge
//   rst_n      - asynchronous active-low reset
//   req_valid  - request present
//   req_ready  - request accepted this cycle when high (RUN state only)
//   req_we     - 1 = write, 0 = read
//   req_addr   - word address
//   req_wdata  - write data
//   req_be     - byte enables, bit k gates byte k
//   rsp_valid  - one-cycle response pulse, one cycle after acceptance
//   rsp_rdata  - read data, 0 for writes and errors
//   rsp_err    - address out of range, qualified by rsp_valid
//   init_done  - high once the clear sequence has completed
module data_mem_sync #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned MEM_SIZE   = 256,
  parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [BE_WIDTH-1:0]   req_be,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  init_done
);

  localparam int unsigned IdxW = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  // One extra bit so MEM_SIZE == 2**ADDR_WIDTH still compares correctly.
  localparam logic [ADDR_WIDTH:0] MemSizeW = (ADDR_WIDTH + 1)'(MEM_SIZE);
  localparam logic [IdxW-1:0]     LastIdx  = IdxW'(MEM_SIZE - 1);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e                state_q;
  logic [IdxW-1:0]       cnt_q;
  logic                  ready_q;
  logic                  done_q;
  logic                  rsp_valid_q;
  logic                  rsp_err_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;

  logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

  logic            accept;
  logic            in_range;
  logic [IdxW-1:0] idx;

  assign accept   = req_valid && ready_q;
  assign in_range = {1'b0, req_addr} < MemSizeW;
  // Only meaningful when in_range; upper address bits never alias.
  assign idx      = req_addr[IdxW-1:0];

  // Control FSM and registered response path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StInit;
      cnt_q       <= '0;
      ready_q     <= 1'b0;
      done_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= accept;
      rsp_err_q   <= accept && !in_range;
      rsp_rdata_q <= '0;
      if (accept && !req_we && in_range) begin
        rsp_rdata_q <= mem[idx];
      end
      case (state_q)
        StInit: begin
          if (cnt_q == LastIdx) begin
            cnt_q   <= '0;
            state_q <= StRun;
            ready_q <= 1'b1;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StRun: begin
          ready_q <= 1'b1;
          done_q  <= 1'b1;
        end
        default: state_q <= StInit;
      endcase
    end
  end

  // Storage: cleared word by word in INIT, byte-enable writes in RUN.
  always_ff @(posedge clk) begin
    if (state_q == StInit) begin
      mem[cnt_q] <= '0;
    end else if (accept && req_we && in_range) begin
      for (int unsigned k = 0; k < BE_WIDTH; k++) begin
        if (req_be[k]) begin
          mem[idx][8*k +: 8] <= req_wdata[8*k +: 8];
        end
      end
    end
  end

  assign req_ready = ready_q;
  assign init_done = done_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_sync.sv
module tb_data_mem_sync;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_be;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        init_done;

  int checks = 0;
  int errors = 0;

  // Reference model: plain array of words, written byte by byte.
  logic [15:0] model_mem [256];

  data_mem_sync dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .init_done (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic [15:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_req(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                           input logic [1:0] be, output logic [15:0] er, output logic ee);
    if (int'(addr) >= 256) begin
      er = 16'h0;
      ee = 1'b1;
    end else begin
      ee = 1'b0;
      er = 16'h0;
      if (we) begin
        for (int k = 0; k < 2; k++) begin
          if (be[k]) model_mem[addr][8*k +: 8] = wdata[8*k +: 8];
        end
      end else begin
        er = model_mem[addr];
      end
    end
  endtask

  task automatic drive(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                       input logic [1:0] be);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Counts edges after release until req_ready rises; bounded.
  task automatic wait_init(input string nm);
    int cycles;
    cycles = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      cycles++;
      if (req_ready) break;
    end
    chk({nm, "_init_cycles"}, cycles, 256);
    chk({nm, "_init_done"}, init_done, 1);
  endtask

  vec_t vecs [$];

  initial begin
    logic [15:0] er;
    logic        ee;
    logic        v;

    vecs = '{
      '{"w5_full",   1'b1, 16'h0005, 16'hABCD, 2'b11, 16'h0000, 1'b0},
      '{"r5_full",   1'b0, 16'h0005, 16'h0000, 2'b00, 16'hABCD, 1'b0},
      '{"w5_lo",     1'b1, 16'h0005, 16'h1234, 2'b01, 16'h0000, 1'b0},
      '{"r5_lo",     1'b0, 16'h0005, 16'h0000, 2'b00, 16'hAB34, 1'b0},
      '{"w5_hi",     1'b1, 16'h0005, 16'h5600, 2'b10, 16'h0000, 1'b0},
      '{"r5_hi",     1'b0, 16'h0005, 16'h0000, 2'b00, 16'h5634, 1'b0},
      '{"w5_be0",    1'b1, 16'h0005, 16'hFFFF, 2'b00, 16'h0000, 1'b0},
      '{"r5_be0",    1'b0, 16'h0005, 16'h0000, 2'b00, 16'h5634, 1'b0},
      '{"w0",        1'b1, 16'h0000, 16'h1111, 2'b11, 16'h0000, 1'b0},
      '{"w100_oor",  1'b1, 16'h0100, 16'hFFFF, 2'b11, 16'h0000, 1'b1},
      '{"r0_noalias",1'b0, 16'h0000, 16'h0000, 2'b00, 16'h1111, 1'b0},
      '{"rFFFF_oor", 1'b0, 16'hFFFF, 16'h0000, 2'b00, 16'h0000, 1'b1},
      '{"w10_1",     1'b1, 16'h000A, 16'h0001, 2'b11, 16'h0000, 1'b0},
      '{"r10_1",     1'b0, 16'h000A, 16'h0000, 2'b00, 16'h0001, 1'b0},
      '{"w10_2",     1'b1, 16'h000A, 16'h0002, 2'b11, 16'h0000, 1'b0},
      '{"r10_2",     1'b0, 16'h000A, 16'h0000, 2'b00, 16'h0002, 1'b0}
    };
    for (int i = 0; i < 256; i++) model_mem[i] = 16'h0;

    // Reset values with a request already pending.
    rst_n = 1'b0;
    drive(1'b0, 16'h00FF, 16'h0, 2'b00);
    #3;
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_init_done", init_done, 0);
    tick();
    rst_n = 1'b1;
    wait_init("t1");
    chk("t1_no_accept_in_init", rsp_valid, 0);
    tick();
    chk("t1_r255_valid", rsp_valid, 1);
    chk("t1_r255_rdata", rsp_rdata, 16'h0000);
    chk("t1_r255_err", rsp_err, 0);

    // Tests 2-5: consecutive requests, each response checked one cycle later.
    foreach (vecs[i]) begin
      drive(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be);
      model_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, er, ee);
      tick();
      chk({vecs[i].name, "_valid"}, rsp_valid, 1);
      chk({vecs[i].name, "_rdata"}, rsp_rdata, vecs[i].exp_rdata);
      chk({vecs[i].name, "_err"}, rsp_err, vecs[i].exp_err);
    end
    req_valid = 1'b0;
    tick();
    chk("idle_valid", rsp_valid, 0);
    chk("idle_rdata", rsp_rdata, 0);
    chk("idle_err", rsp_err, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [15:0] a;
      logic        w;
      v = ($urandom_range(0, 3) != 0);
      w = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0:       a = 16'($urandom);
        1:       a = 16'hFFFF;
        default: a = 16'($urandom_range(0, 299));
      endcase
      if (v) begin
        drive(w, a, 16'($urandom), 2'($urandom));
        model_req(w, a, req_wdata, req_be, er, ee);
      end else begin
        req_valid = 1'b0;
        er = 16'h0;
        ee = 1'b0;
      end
      tick();
      chk("rnd_ready", req_ready, 1);
      chk("rnd_valid", rsp_valid, v);
      chk("rnd_rdata", rsp_rdata, er);
      chk("rnd_err", rsp_err, ee);
    end

    // Test 6: reset mid-read drops the response and reruns the clear.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'(i), 16'(16'hA5A0 + i), 2'b11);
      tick();
    end
    drive(1'b0, 16'h0002, 16'h0, 2'b00);
    tick();
    chk("t6_pre_valid", rsp_valid, 1);
    chk("t6_pre_rdata", rsp_rdata, 16'hA5A2);
    drive(1'b0, 16'h0003, 16'h0, 2'b00);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", rsp_valid, 0);
    chk("t6_rst_rdata", rsp_rdata, 0);
    chk("t6_rst_ready", req_ready, 0);
    chk("t6_rst_done", init_done, 0);
    for (int i = 0; i < 256; i++) model_mem[i] = 16'h0;
    tick();
    tick();
    chk("t6_hold_valid", rsp_valid, 0);
    rst_n = 1'b1;
    wait_init("t6");
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 16'(i), 16'h0, 2'b00);
      tick();
      chk("t6_clr_valid", rsp_valid, 1);
      chk("t6_clr_rdata", rsp_rdata, 16'h0000);
    end
    req_valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
